// File: rtl/jelly_bean_taster_array.sv
// jelly_bean_taster_array
// NUM_CH valid/ready command channels, each feeding its own small FIFO. A round-robin
// arbiter pops at most one entry per cycle. WRITE entries update the channel's last taste
// and the saturating statistics counters. READ entries return that channel's last taste
// on a single channel-tagged result stream with valid/ready back-pressure.
module jelly_bean_taster_array #(
    parameter int NUM_CH       = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 16,
    parameter int YUCKY_FLAVOR = 4,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     in_valid,
    output logic [NUM_CH-1:0]     in_ready,
    input  logic [3*NUM_CH-1:0]   in_flavor,
    input  logic [2*NUM_CH-1:0]   in_color,
    input  logic [NUM_CH-1:0]     in_sugar_free,
    input  logic [NUM_CH-1:0]     in_sour,
    input  logic [2*NUM_CH-1:0]   in_command,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_taste,
    output logic [CH_W-1:0]       out_ch,
    input  logic                  clr_cnt,
    output logic [CNT_W-1:0]      yummy_cnt,
    output logic [CNT_W-1:0]      yucky_cnt
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 9;   // {flavor[8:6], color[5:4], sugar_free[3], sour[2], command[1:0]}

    localparam logic [1:0] CMD_READ      = 2'd1;
    localparam logic [1:0] CMD_WRITE     = 2'd2;
    localparam logic [1:0] TASTE_UNKNOWN = 2'd0;
    localparam logic [1:0] TASTE_YUMMY   = 2'd1;
    localparam logic [1:0] TASTE_YUCKY   = 2'd2;

    localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);
    localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Taste of a WRITE: a zero flavor is unknown, the configured flavor turns yucky when sour.
    function automatic logic [1:0] taste_of(input logic [2:0] flavor, input logic sour);
        logic [1:0] t;
        if (flavor == 3'd0) begin
            t = TASTE_UNKNOWN;
        end else if ((flavor == 3'(YUCKY_FLAVOR)) && sour) begin
            t = TASTE_YUCKY;
        end else begin
            t = TASTE_YUMMY;
        end
        return t;
    endfunction

    logic [ENTRY_W-1:0] mem_q        [NUM_CH][FIFO_DEPTH];
    logic [ENTRY_W-1:0] mem_d        [NUM_CH][FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_q     [NUM_CH];
    logic [PTR_W:0]     wr_ptr_d     [NUM_CH];
    logic [PTR_W:0]     rd_ptr_q     [NUM_CH];
    logic [PTR_W:0]     rd_ptr_d     [NUM_CH];
    logic [1:0]         last_taste_q [NUM_CH];
    logic [1:0]         last_taste_d [NUM_CH];
    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               out_valid_q, out_valid_d;
    logic [1:0]         out_taste_q, out_taste_d;
    logic [CH_W-1:0]    out_ch_q, out_ch_d;
    logic [CNT_W-1:0]   yummy_cnt_q, yummy_cnt_d;
    logic [CNT_W-1:0]   yucky_cnt_q, yucky_cnt_d;

    logic [NUM_CH-1:0]  empty_s;
    logic [NUM_CH-1:0]  full_s;
    logic               serve_en_s;
    logic               grant_vld_s;
    logic [CH_W-1:0]    grant_ch_s;
    logic [CH_W-1:0]    idx_s;
    logic [1:0]         pop_cmd_s;
    logic [2:0]         pop_flavor_s;
    logic               pop_sour_s;
    logic [1:0]         pop_taste_s;

    // FIFO occupancy flags from the registered pointers; the extra MSB separates full from empty.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            empty_s[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full_s[i]  = (wr_ptr_q[i][PTR_W] != rd_ptr_q[i][PTR_W]) &&
                         (wr_ptr_q[i][PTR_W-1:0] == rd_ptr_q[i][PTR_W-1:0]);
        end
    end

    assign in_ready = ~full_s;

    // Round-robin grant: the first non-empty FIFO at or after rr_ptr, only when the result slot can take it.
    always_comb begin
        serve_en_s  = !out_valid_q || out_ready;
        grant_vld_s = 1'b0;
        grant_ch_s  = '0;
        idx_s       = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx_s = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
            if (serve_en_s && !empty_s[idx_s]) begin
                grant_vld_s = 1'b1;
                grant_ch_s  = idx_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Fields of the head entry of the granted FIFO.
    always_comb begin
        pop_cmd_s    = mem_q[grant_ch_s][rd_ptr_q[grant_ch_s][PTR_W-1:0]][1:0];
        pop_sour_s   = mem_q[grant_ch_s][rd_ptr_q[grant_ch_s][PTR_W-1:0]][2];
        pop_flavor_s = mem_q[grant_ch_s][rd_ptr_q[grant_ch_s][PTR_W-1:0]][8:6];
        pop_taste_s  = taste_of(pop_flavor_s, pop_sour_s);
    end

    // Next state: enqueue accepted READ/WRITE beats, execute the granted entry, update counters.
    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        last_taste_d = last_taste_q;
        rr_ptr_d     = rr_ptr_q;
        out_taste_d  = out_taste_q;
        out_ch_d     = out_ch_q;
        yummy_cnt_d  = yummy_cnt_q;
        yucky_cnt_d  = yucky_cnt_q;

        for (int i = 0; i < NUM_CH; i++) begin
            if (in_valid[i] && !full_s[i] &&
                ((in_command[2*i +: 2] == CMD_READ) || (in_command[2*i +: 2] == CMD_WRITE))) begin
                mem_d[i][wr_ptr_q[i][PTR_W-1:0]] = {in_flavor[3*i +: 3], in_color[2*i +: 2],
                                                    in_sugar_free[i], in_sour[i],
                                                    in_command[2*i +: 2]};
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_ONE;
            end else begin
                wr_ptr_d[i] = wr_ptr_q[i];
            end
        end

        if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (grant_vld_s) begin
            rd_ptr_d[grant_ch_s] = rd_ptr_q[grant_ch_s] + PTR_ONE;
            if (grant_ch_s == CH_LAST) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_ch_s + CH_ONE;
            end
            case (pop_cmd_s)
                CMD_WRITE: begin
                    last_taste_d[grant_ch_s] = pop_taste_s;
                    if ((pop_taste_s == TASTE_YUMMY) && (yummy_cnt_q != CNT_MAX)) begin
                        yummy_cnt_d = yummy_cnt_q + CNT_ONE;
                    end else if ((pop_taste_s == TASTE_YUCKY) && (yucky_cnt_q != CNT_MAX)) begin
                        yucky_cnt_d = yucky_cnt_q + CNT_ONE;
                    end else begin
                        yummy_cnt_d = yummy_cnt_q;
                    end
                end
                CMD_READ: begin
                    out_valid_d = 1'b1;
                    out_taste_d = last_taste_q[grant_ch_s];
                    out_ch_d    = grant_ch_s;
                end
                default: begin
                    out_taste_d = out_taste_q;
                end
            endcase
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        if (clr_cnt) begin
            yummy_cnt_d = '0;
            yucky_cnt_d = '0;
        end else begin
            yummy_cnt_d = yummy_cnt_d;
        end
    end

    // State registers; reset empties every FIFO and drops any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '{default: '0};
            rd_ptr_q     <= '{default: '0};
            last_taste_q <= '{default: TASTE_UNKNOWN};
            rr_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_taste_q  <= TASTE_UNKNOWN;
            out_ch_q     <= '0;
            yummy_cnt_q  <= '0;
            yucky_cnt_q  <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_taste_q <= last_taste_d;
            rr_ptr_q     <= rr_ptr_d;
            out_valid_q  <= out_valid_d;
            out_taste_q  <= out_taste_d;
            out_ch_q     <= out_ch_d;
            yummy_cnt_q  <= yummy_cnt_d;
            yucky_cnt_q  <= yucky_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_taste = out_taste_q;
    assign out_ch    = out_ch_q;
    assign yummy_cnt = yummy_cnt_q;
    assign yucky_cnt = yucky_cnt_q;

endmodule
